// File: rtl/tc141_falign.sv
// Frame aligner: buffers early stream A and realigns it to late stream B on start-of-frame.
// Define TC141_FALIGN_SKEW_EN to keep the measured A-to-B skew on o_skew.
module tc141_falign #(
    parameter int DAT = 8,
    parameter int DEP = 16,
    parameter int PTW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           a_vld,
    input  logic           a_sof,
    input  logic [DAT-1:0] a_dat,
    input  logic           b_vld,
    input  logic           b_sof,
    input  logic [DAT-1:0] b_dat,
    output logic           o_vld,
    output logic           o_sof,
    output logic [DAT-1:0] o_adat,
    output logic [DAT-1:0] o_bdat,
    output logic           lock,
    output logic           err,
    output logic [PTW:0]   o_skew
);

    typedef enum logic [1:0] {
        HUNT,
        WAIT,
        LOCK
    } st_t;

    st_t st, st_nx;

    logic [PTW:0]   wp, rp, occ_nx;
    logic [DAT:0]   mem [DEP];
    logic [DAT:0]   head;
    logic           full, empty;
    logic           push, pop, fault, out_v, lock_ev;
    logic [DAT-1:0] out_a;

    assign full  = (wp[PTW] != rp[PTW]) && (wp[PTW-1:0] == rp[PTW-1:0]);
    assign empty = (wp == rp);
    assign head  = mem[rp[PTW-1:0]];
    assign lock  = (st == LOCK);

    always_comb begin
        st_nx   = st;
        push    = 1'b0;
        pop     = 1'b0;
        fault   = 1'b0;
        out_v   = 1'b0;
        out_a   = head[DAT-1:0];
        lock_ev = 1'b0;
        unique case (st)
            HUNT: begin
                if (a_vld && a_sof) begin
                    if (b_vld && b_sof) begin
                        out_v   = 1'b1;
                        out_a   = a_dat;
                        st_nx   = LOCK;
                        lock_ev = 1'b1;
                    end else begin
                        push  = 1'b1;
                        st_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (a_vld && full) begin
                    fault = 1'b1;
                end else begin
                    push = a_vld;
                    if (b_vld && b_sof) begin
                        pop     = 1'b1;
                        out_v   = 1'b1;
                        st_nx   = LOCK;
                        lock_ev = 1'b1;
                    end
                end
            end
            LOCK: begin
                if (a_vld && full) begin
                    fault = 1'b1;
                end else if (b_vld && empty) begin
                    // empty FIFO with A present means zero skew: pass a_dat straight through
                    if (!a_vld || (a_sof != b_sof)) begin
                        fault = 1'b1;
                    end else begin
                        out_v = 1'b1;
                        out_a = a_dat;
                    end
                end else begin
                    push = a_vld;
                    if (b_vld) begin
                        if (head[DAT] != b_sof) begin
                            fault = 1'b1;
                        end else begin
                            pop   = 1'b1;
                            out_v = 1'b1;
                        end
                    end
                end
            end
            default: st_nx = HUNT;
        endcase
        if (fault) begin
            st_nx   = HUNT;
            push    = 1'b0;
            pop     = 1'b0;
            out_v   = 1'b0;
            lock_ev = 1'b0;
        end
    end

    assign occ_nx = wp - rp + {{PTW{1'b0}}, push} - {{PTW{1'b0}}, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= HUNT;
            wp <= '0;
            rp <= '0;
        end else begin
            st <= st_nx;
            if (fault) begin
                rp <= wp;
            end else begin
                wp <= wp + {{PTW{1'b0}}, push};
                rp <= rp + {{PTW{1'b0}}, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[PTW-1:0]] <= {a_sof, a_dat};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_vld  <= 1'b0;
            o_sof  <= 1'b0;
            o_adat <= '0;
            o_bdat <= '0;
            err    <= 1'b0;
        end else begin
            o_vld <= out_v;
            o_sof <= out_v & b_sof;
            err   <= fault;
            if (out_v) begin
                o_adat <= out_a;
                o_bdat <= b_dat;
            end
        end
    end

`ifdef TC141_FALIGN_SKEW_EN
    logic [PTW:0] skew_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) skew_q <= '0;
        else if (lock_ev) skew_q <= occ_nx;
    end

    assign o_skew = skew_q;
`else
    logic unused_skew;

    assign unused_skew = ^{occ_nx, lock_ev};
    assign o_skew      = '0;
`endif

endmodule

// File: tb/tb_tc141_falign.sv
// Scoreboard bench for tc141_falign: queue-based reference model, directed
// alignment scenarios and randomized traffic.
module tb_tc141_falign;
    localparam int DAT = 8;
    localparam int DEP = 16;
    localparam int PTW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           a_vld, a_sof, b_vld, b_sof;
    logic [DAT-1:0] a_dat, b_dat;
    logic           o_vld, o_sof, lock, err;
    logic [DAT-1:0] o_adat, o_bdat;
    logic [PTW:0]   o_skew;

    always #5 clk = ~clk;

    tc141_falign #(.DAT(DAT), .DEP(DEP), .PTW(PTW)) dut (
        .clk(clk), .rst(rst),
        .a_vld(a_vld), .a_sof(a_sof), .a_dat(a_dat),
        .b_vld(b_vld), .b_sof(b_sof), .b_dat(b_dat),
        .o_vld(o_vld), .o_sof(o_sof), .o_adat(o_adat), .o_bdat(o_bdat),
        .lock(lock), .err(err), .o_skew(o_skew)
    );

    typedef struct packed {
        logic           sof;
        logic [DAT-1:0] a;
        logic [DAT-1:0] b;
    } ow_t;

    typedef struct packed {
        logic         ov;
        logic         err;
        logic         lock;
        logic [PTW:0] skew;
    } se_t;

    ow_t exp_q[$];
    se_t est_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // reference model: 0 hunting, 1 waiting for B, 2 locked
    int           m_st = 0;
    logic [DAT:0] mq[$];
    int           m_skew = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model(input logic av, as, input logic [DAT-1:0] ad,
                         input logic bv, bs, input logic [DAT-1:0] bd);
        logic [DAT:0]   h;
        logic [DAT-1:0] oa;
        bit             e, ov;
        se_t            s;
        e  = 0;
        ov = 0;
        oa = '0;
        case (m_st)
            0: if (av && as) begin
                if (bv && bs) begin
                    ov = 1; oa = ad; m_st = 2; m_skew = 0;
                end else begin
                    mq.push_back({as, ad}); m_st = 1;
                end
            end
            1: if (av && mq.size() == DEP) e = 1;
            else begin
                if (bv && bs) begin
                    h = mq.pop_front(); ov = 1; oa = h[DAT-1:0]; m_st = 2;
                end
                if (av) mq.push_back({as, ad});
                if (ov) m_skew = mq.size();
            end
            default: if (av && mq.size() == DEP) e = 1;
            else if (bv) begin
                if (mq.size() == 0) begin
                    if (av && as == bs) begin ov = 1; oa = ad; end
                    else e = 1;
                end else begin
                    h = mq.pop_front();
                    if (h[DAT] != bs) e = 1;
                    else begin
                        ov = 1; oa = h[DAT-1:0];
                        if (av) mq.push_back({as, ad});
                    end
                end
            end else if (av) mq.push_back({as, ad});
        endcase
        if (e) begin
            mq.delete();
            m_st = 0;
        end
        s.ov   = ov;
        s.err  = e;
        s.lock = (m_st == 2);
`ifdef TC141_FALIGN_SKEW_EN
        s.skew = (PTW+1)'(m_skew);
`else
        s.skew = '0;
`endif
        est_q.push_back(s);
        if (ov) exp_q.push_back({bs & 1'b1, oa, bd});
    endtask

    task automatic beat(input logic av, as, input logic [DAT-1:0] ad,
                        input logic bv, bs, input logic [DAT-1:0] bd);
        @(negedge clk);
        a_vld = av; a_sof = as; a_dat = ad;
        b_vld = bv; b_sof = bs; b_dat = bd;
        model(av, as, ad, bv, bs, bd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a_vld = 0; a_sof = 0; a_dat = '0;
        b_vld = 0; b_sof = 0; b_dat = '0;
        mq.delete();
        m_st = 0;
        m_skew = 0;
        @(negedge clk);
        chk("rst_o_vld", 32'(o_vld), 0);
        chk("rst_o_sof", 32'(o_sof), 0);
        chk("rst_o_adat", 32'(o_adat), 0);
        chk("rst_o_bdat", 32'(o_bdat), 0);
        chk("rst_lock", 32'(lock), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_o_skew", 32'(o_skew), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // A frame of alen words, B copy of blen words delayed by dly; sof2 adds a
    // second frame start, early injects an extra B-only sof
    task automatic run_stream(input int dly, alen, blen, sof2, early);
        logic [DAT-1:0] d[64];
        int tot;
        for (int i = 0; i < 64; i++) d[i] = DAT'($urandom);
        tot = (alen > blen + dly) ? alen : blen + dly;
        for (int t = 0; t < tot; t++) begin
            int  j;
            bit  av, bv, as, bs;
            j  = t - dly;
            av = (t < alen);
            bv = (j >= 0) && (j < blen);
            as = av && (t == 0 || t == sof2);
            bs = bv && (j == 0 || j == sof2 || j == early);
            beat(av, as, av ? d[t] : '0, bv, bs, bv ? d[j] : '0);
        end
        repeat (2) beat(0, 0, '0, 0, 0, '0);
    endtask

    // monitor: consumes one expected status per driven beat, and one expected
    // word whenever the DUT presents o_vld
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (est_q.size() > 0) begin
                se_t s;
                s = est_q.pop_front();
                chk("o_vld", 32'(o_vld), 32'(s.ov));
                chk("err", 32'(err), 32'(s.err));
                chk("lock", 32'(lock), 32'(s.lock));
                chk("o_skew", 32'(o_skew), 32'(s.skew));
                if (s.ov && exp_q.size() > 0) begin
                    ow_t w;
                    w = exp_q.pop_front();
                    chk("o_sof", 32'(o_sof), 32'(w.sof));
                    chk("o_adat", 32'(o_adat), 32'(w.a));
                    chk("o_bdat", 32'(o_bdat), 32'(w.b));
                end
            end else if (!rst) begin
                chk("idle_o_vld", 32'(o_vld), 0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        a_vld = 0; a_sof = 0; a_dat = '0;
        b_vld = 0; b_sof = 0; b_dat = '0;
        do_reset();
        run_stream(3, 20, 20, -1, -1);
        do_reset();
        run_stream(0, 12, 12, -1, -1);
        do_reset();
        run_stream(17, 30, 13, -1, -1);
        do_reset();
        run_stream(3, 20, 20, 12, 10);
        do_reset();
        run_stream(3, 10, 14, -1, -1);
        do_reset();
        run_stream(7, 5, 0, -1, -1);
        do_reset();
        run_stream(2, 10, 10, -1, -1);
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            beat(($urandom % 4) != 0, ($urandom % 8) == 0, DAT'($urandom),
                 ($urandom % 4) != 0, ($urandom % 8) == 0, DAT'($urandom));
        end
        repeat (3) beat(0, 0, '0, 0, 0, '0);
        @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tc141_falign.md
TC141_FALIGN -- requirements
Module: tc141_falign

Interface
REQ-001 The block SHALL have parameter DAT, default 8, giving the width of each data word.
REQ-002 The block SHALL have parameter DEP, default 16, giving the A-stream buffer depth in words; DEP is a power of 2 and at least 2.
REQ-003 The block SHALL have parameter PTW, default 4, giving the pointer width; PTW equals log2(DEP).
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port a_vld, input, 1 bit: word valid on the early stream A.
REQ-007 Port a_sof, input, 1 bit: start-of-frame marker for stream A, qualified by a_vld.
REQ-008 Port a_dat, input, DAT bits: stream A data word.
REQ-009 Port b_vld, input, 1 bit: word valid on the late stream B, which has passed through a fixed-delay flop pipeline.
REQ-010 Port b_sof, input, 1 bit: start-of-frame marker for stream B, qualified by b_vld.
REQ-011 Port b_dat, input, DAT bits: stream B data word.
REQ-012 Port o_vld, output, 1 bit: aligned output word pair is valid.
REQ-013 Port o_sof, output, 1 bit: aligned start-of-frame marker.
REQ-014 Port o_adat, output, DAT bits: realigned stream A word.
REQ-015 Port o_bdat, output, DAT bits: stream B word.
REQ-016 Port lock, output, 1 bit: the aligner is in LOCK.
REQ-017 Port err, output, 1 bit: one-cycle pulse on any alignment fault.
REQ-018 Port o_skew, output, PTW+1 bits: measured A-to-B skew in words.

Function
REQ-019 The block SHALL implement three states: HUNT, WAIT and LOCK.
REQ-020 Stream A SHALL be buffered in a DEP-entry circular FIFO with PTW+1-bit write and read pointers; pointers SHALL wrap modulo 2*DEP; full and empty SHALL be derived from the MSB and the low PTW bits.
REQ-021 In HUNT, a_vld words without a_sof SHALL be discarded, and b_vld words SHALL be ignored.
REQ-022 In HUNT, an a_vld&a_sof beat SHALL be written to the FIFO and the state SHALL move to WAIT.
REQ-023 In WAIT, every a_vld beat SHALL be written to the FIFO.
REQ-024 In WAIT, on a b_vld&b_sof beat the FIFO head SHALL be popped, the state SHALL move to LOCK and the skew counter SHALL be captured.
REQ-025 In WAIT, a b_vld beat without b_sof SHALL be ignored.
REQ-026 In WAIT or LOCK, an a_vld beat while the FIFO is full SHALL pulse err, flush the FIFO and return the state to HUNT.
REQ-027 In LOCK, every a_vld beat SHALL be pushed and every b_vld beat SHALL pop one A word; a simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-028 In LOCK, a b_vld beat while the FIFO is empty and a_vld is low SHALL pulse err, flush the FIFO and return the state to HUNT.
REQ-029 In LOCK, a b_vld beat while the FIFO is empty and a_vld is high SHALL bypass a_dat directly to the output (zero skew).
REQ-030 In LOCK, if the popped entry's stored sof bit differs from b_sof, the block SHALL pulse err, suppress o_vld for that beat, flush the FIFO and return the state to HUNT.
REQ-031 In HUNT, simultaneous a_vld&a_sof and b_vld&b_sof SHALL lock directly with skew 0 via bypass.
REQ-032 The outputs o_vld, o_sof, o_adat and o_bdat SHALL be registered, with a latency of 1 cycle from the b_vld beat.
REQ-033 o_sof SHALL equal b_sof of the originating beat.
REQ-034 lock SHALL be high exactly while the state is LOCK.
REQ-035 A flush SHALL set the read pointer equal to the write pointer in the same cycle in which the fault is detected.

Reset
REQ-036 While rst is high, the state SHALL be HUNT, both pointers SHALL be 0, and o_vld, o_sof, lock, err and o_skew SHALL be 0.
REQ-037 While rst is high, o_adat and o_bdat SHALL be 0.
REQ-038 The FIFO storage array SHALL not be reset.
REQ-039 Assertion of rst mid-frame SHALL abandon the buffered data with no err pulse.

Configuration
REQ-040 With macro TC141_FALIGN_SKEW_EN defined, o_skew SHALL hold the FIFO occupancy at the lock event, counted after the pop, until the next lock or reset.
REQ-041 With TC141_FALIGN_SKEW_EN undefined, o_skew SHALL be tied to 0, no skew register SHALL exist, and the port list SHALL be unchanged.

Verification
REQ-042 Bench scenario: A frame with a_sof, B identical stream delayed 3 beats -> lock rises on the B sof beat plus 1; o_adat==o_bdat for every beat; o_skew==3 (macro on) or 0 (macro off).
REQ-043 Bench scenario: B delayed 0 beats (simultaneous sof) -> lock via bypass, o_vld one cycle after each b_vld, o_skew==0.
REQ-044 Bench scenario: B delay 17 with DEP=16 -> err pulse on the 17th a_vld push, lock stays 0, state returns to HUNT.
REQ-045 Bench scenario: in LOCK, a B sof is inserted 2 beats early -> err pulse, no o_vld for that beat, lock drops next cycle.
REQ-046 Bench scenario: in LOCK, A stalls so the FIFO drains to empty and b_vld arrives -> err pulse, state HUNT.
REQ-047 Bench scenario: rst asserted mid-frame while 5 words are buffered -> all outputs 0 while rst is high; after release, the next a_sof and b_sof pair re-locks correctly.
